// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command queue.
//   ENTRY_W  : width of one queued entry {kind[1:0], data[15:0]}
//   kind_e   : entry kind encodings KIND_C / KIND_D8 / KIND_D16
//   state_e  : issue FSM encodings IDLE / ISSUE / SETTLE / WAIT
//   entry_t  : packed view of one FIFO entry
package lcd_pkg;

  localparam int ENTRY_W = 18;

  typedef enum logic [1:0] {
    KIND_C   = 2'd0,
    KIND_D8  = 2'd1,
    KIND_D16 = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [15:0] data;
  } entry_t;

endpackage

// File: rtl/lcd_cmd_queue_if.sv
// Bus between the CPU-side LCD register, the queue and the LCD SPI driver.
//   loadC/loadD8/loadD16/in : CPU write strobes and write data
//   out                     : status word read by the CPU
//   lcd_load*/lcd_in        : replayed strobes and data towards the LCD driver
//   lcd_busy                : LCD driver transfer in progress
// master = CPU plus LCD driver environment, slave = the queue.
interface lcd_cmd_queue_if;
  logic        loadC;
  logic        loadD8;
  logic        loadD16;
  logic [15:0] in;
  logic [15:0] out;
  logic        lcd_loadC;
  logic        lcd_loadD8;
  logic        lcd_loadD16;
  logic [15:0] lcd_in;
  logic        lcd_busy;

  modport master (
    output loadC, loadD8, loadD16, in, lcd_busy,
    input  out, lcd_loadC, lcd_loadD8, lcd_loadD16, lcd_in
  );

  modport slave (
    input  loadC, loadD8, loadD16, in, lcd_busy,
    output out, lcd_loadC, lcd_loadD8, lcd_loadD16, lcd_in
  );
endinterface

// File: rtl/lcd_fifo.sv
// Synchronous FIFO, power-of-two depth.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request; ignored when full unless popping in the same cycle
//   pop/rdata  : read request; rdata is the head entry, combinational
//   count      : entries held (0..DEPTH), full, empty
module lcd_fifo #(
  parameter int  WIDTH = 18,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rptr];

  // NOTE: storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_queue.sv
// Write queue between the memory-mapped LCD register and the LCD SPI driver.
// The CPU writes at full rate; entries are replayed one at a time, each
// waiting for the driver's busy to clear. The CPU polls the status word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lcd_cmd_queue_if.slave (CPU strobes/data, status, LCD side)
//   drop_count : dropped-write counter, present only with LCD_QUEUE_STATS_EN
// Status word: [15]=busy [14]=full [13]=overflow (sticky) [DEPTH_W:0]=count.
// Optional feature macro: LCD_QUEUE_STATS_EN.
module lcd_cmd_queue
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_cmd_queue_if.slave    bus
`ifdef LCD_QUEUE_STATS_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  entry_t           wr_entry;
  entry_t           head;
  logic             any_load;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [DEPTH_W:0] count;
  logic             overflow;
  kind_e            kind_r;
  logic [15:0]      lcd_in_r;
  state_e           state_q;
  state_e           state_d;

  // Write arbitration: simultaneous strobes collapse to one entry, C > D16 > D8.
  assign any_load = bus.loadC || bus.loadD8 || bus.loadD16;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_entry.kind = KIND_D8;
    wr_entry.data = {8'h00, bus.in[7:0]};
    if (bus.loadC) begin
      wr_entry.kind = KIND_C;
    end else if (bus.loadD16) begin
      wr_entry.kind = KIND_D16;
      wr_entry.data = bus.in;
    end
  end

  lcd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (any_load),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A write into a full queue survives only if the head leaves that cycle.
  assign drop = any_load && full && !pop;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef LCD_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
  end
`endif

  // Issue FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue FSM: next state. SETTLE gives the driver one cycle to raise busy,
  // so busy still high from a previous transfer is never seen in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = WAIT;
      WAIT:    if (!bus.lcd_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue FSM: outputs. Strobes decode straight from state so reset kills them at once.
  always_comb begin
    pop             = (state_q == IDLE) && !empty;
    bus.lcd_loadC   = (state_q == ISSUE) && (kind_r == KIND_C);
    bus.lcd_loadD8  = (state_q == ISSUE) && (kind_r == KIND_D8);
    bus.lcd_loadD16 = (state_q == ISSUE) && (kind_r == KIND_D16);
  end

  // Popped entry is held here so lcd_in stays stable for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_r   <= KIND_C;
      lcd_in_r <= '0;
    end else if (pop) begin
      kind_r   <= head.kind;
      lcd_in_r <= head.data;
    end
  end

  assign bus.lcd_in = lcd_in_r;

  always_comb begin
    bus.out            = '0;
    bus.out[15]        = (count != '0) || (state_q != IDLE);
    bus.out[14]        = full;
    bus.out[13]        = overflow;
    bus.out[DEPTH_W:0] = count;
  end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Scoreboard bench for lcd_cmd_queue: stimulus pushes the expected LCD-side
// entry, a negedge monitor pops and compares on every lcd_load* strobe.
// A small LCD model raises lcd_busy for busy_len cycles after each strobe.
module tb_lcd_cmd_queue;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_cmd_queue_if bus ();
`ifdef LCD_QUEUE_STATS_EN
  logic [15:0] drop_count;
`endif

  lcd_cmd_queue #(
    .DEPTH   (16),
    .DEPTH_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LCD_QUEUE_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int     vectors = 0;
  int     miscompares = 0;
  entry_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // LCD driver model.
  int   busy_len = 20;
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  assign bus.lcd_busy = hold_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else if (bus.lcd_loadC || bus.lcd_loadD8 || bus.lcd_loadD16) busy_cnt = busy_len;
    else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
  end

  // Monitor: compares each strobe against the scoreboard and checks lcd_in hold.
  int          strobes;
  entry_t      exp_e;
  kind_e       act_kind;
  logic [15:0] last_data;
  bit          have_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 1'b0;
    end else begin
      strobes = int'(bus.lcd_loadC) + int'(bus.lcd_loadD8) + int'(bus.lcd_loadD16);
      if (strobes != 0) begin
        check("strobe_onehot", strobes, 1);
        act_kind = bus.lcd_loadC ? KIND_C : (bus.lcd_loadD8 ? KIND_D8 : KIND_D16);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got kind %0d data %h, expected no strobe", act_kind, bus.lcd_in);
        end else begin
          exp_e = sb.pop_front();
          check("strobe_kind", act_kind, exp_e.kind);
          check("strobe_data", bus.lcd_in, exp_e.data);
        end
        last_data = bus.lcd_in;
        have_last = 1'b1;
      end else if (bus.lcd_busy && have_last) begin
        check("lcd_in_hold", bus.lcd_in, last_data);
      end
    end
  end

  task automatic expect_entry(input kind_e k, input logic [15:0] d);
    entry_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  // Drives one CPU write for exactly one cycle, starting at a negedge.
  task automatic write(input logic c, input logic d8, input logic d16, input logic [15:0] d);
    bus.loadC   = c;
    bus.loadD8  = d8;
    bus.loadD16 = d16;
    bus.in      = d;
    @(negedge clk);
    bus.loadC   = 1'b0;
    bus.loadD8  = 1'b0;
    bus.loadD16 = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && bus.out[15]; i++) @(negedge clk);
    check(name, bus.out[15], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.loadC   = 1'b0;
    bus.loadD8  = 1'b0;
    bus.loadD16 = 1'b0;
    bus.in      = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_out", bus.out, 16'h0000);
    check("rst_strobes", {bus.lcd_loadC, bus.lcd_loadD8, bus.lcd_loadD16}, 3'b000);
    check("rst_lcd_in", bus.lcd_in, 16'h0000);
`ifdef LCD_QUEUE_STATS_EN
    check("rst_drop_count", drop_count, 16'h0000);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single command, two-cycle latency, busy drops after LCD busy ends.
    busy_len = 20;
    expect_entry(KIND_C, 16'h002A);
    write(1'b1, 1'b0, 1'b0, 16'h002A);
    check("t1_no_early_strobe", bus.lcd_loadC, 1'b0);
    check("t1_status_busy", bus.out[15], 1'b1);
    @(negedge clk);
    check("t1_latency_strobe", bus.lcd_loadC, 1'b1);
    repeat (5) @(negedge clk);
    check("t1_busy_during_xfer", bus.out[15], 1'b1);
    wait_idle("t1_idle", 60);
    check("t1_lcd_busy_low", bus.lcd_busy, 1'b0);

    // D16 word, then three D8 bytes back-to-back queued behind it.
    expect_entry(KIND_D16, 16'h7D7B);
    write(1'b0, 1'b0, 1'b1, 16'd32123);
    repeat (4) @(negedge clk);
    expect_entry(KIND_D8, 16'h0011);
    expect_entry(KIND_D8, 16'h0022);
    expect_entry(KIND_D8, 16'h0033);
    write(1'b0, 1'b1, 1'b0, 16'h0011);
    write(1'b0, 1'b1, 1'b0, 16'h0022);
    write(1'b0, 1'b1, 1'b0, 16'h0033);
    check("t2_count_peak", bus.out[4:0], 5'd3);
    wait_idle("t2_idle", 300);

    // Simultaneous loadC + loadD8: one entry, command kind, low byte only.
    busy_len = 3;
    expect_entry(KIND_C, 16'h0034);
    write(1'b1, 1'b1, 1'b0, 16'h1234);
    check("t4_one_entry", bus.out[4:0], 5'd1);
    wait_idle("t4_idle", 40);

    // Busy held: fill to DEPTH, drop one, then accept a write on the pop cycle.
    hold_busy = 1'b1;
    expect_entry(KIND_D8, 16'h0055);
    write(1'b0, 1'b1, 1'b0, 16'hAA55);
    repeat (4) @(negedge clk);
    check("t5_wait_empty", bus.out[4:0], 5'd0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_entry(KIND_D16, 16'(16'h1000 + i));
      write(1'b0, 1'b0, 1'b1, 16'(16'h1000 + i));
    end
    check("t5_count_full", bus.out[4:0], 5'd16);
    check("t5_full_flag", bus.out[14], 1'b1);
    check("t5_overflow", bus.out[13], 1'b1);
`ifdef LCD_QUEUE_STATS_EN
    check("t5_drop_count", drop_count, 16'd1);
`endif
    hold_busy = 1'b0;
    @(negedge clk);
    check("t5_full_before_pop", bus.out[14], 1'b1);
    expect_entry(KIND_C, 16'h00AB);
    write(1'b1, 1'b0, 1'b0, 16'h00AB);
    check("t5_pop_cycle_count", bus.out[4:0], 5'd16);
`ifdef LCD_QUEUE_STATS_EN
    check("t5_drop_count_same", drop_count, 16'd1);
`endif
    wait_idle("t5_idle", 400);
    check("t5_overflow_sticky", bus.out[13], 1'b1);

    // Reset in WAIT with 5 entries queued.
    busy_len = 20;
    expect_entry(KIND_D8, 16'h0001);
    for (int i = 0; i < 6; i++) write(1'b0, 1'b1, 1'b0, 16'(i + 1));
    repeat (4) @(negedge clk);
    check("t6_count5", bus.out[4:0], 5'd5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", bus.out, 16'h0000);
    check("t6_rst_strobes", {bus.lcd_loadC, bus.lcd_loadD8, bus.lcd_loadD16}, 3'b000);
    check("t6_rst_lcd_in", bus.lcd_in, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_after_release", bus.out, 16'h0000);
`ifdef LCD_QUEUE_STATS_EN
    check("t6_drop_count_rst", drop_count, 16'h0000);
`endif

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
